// File: rtl/ysyx_22041207_pkg.sv
// Shared types and constants for the ysyx_22041207 memory-side blocks.
package ysyx_22041207_pkg;

  // Read arbiter transaction phases: wait for a request, present the
  // address downstream, then forward the returning data to the owner.
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  // Owner id of the outstanding read transaction.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/ysyx_22041207_rd_arbiter.sv
// Two-requester (IF / LS) read arbiter with a single outstanding transaction.
// LS normally wins; a saturating streak counter lets a waiting IF through
// after MAX_LS_STREAK back-to-back LS grants so instruction fetch never starves.
module ysyx_22041207_rd_arbiter
  import ysyx_22041207_pkg::*;
#(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_r_valid_i,
  output logic              if_r_ready_o,
  input  logic [ADDR_W-1:0] if_r_addr_i,
  input  logic [7:0]        if_r_size_i,
  output logic              if_data_valid_o,
  input  logic              if_data_ready_i,
  input  logic              ls_r_valid_i,
  output logic              ls_r_ready_o,
  input  logic [ADDR_W-1:0] ls_r_addr_i,
  input  logic [7:0]        ls_r_size_i,
  output logic              ls_data_valid_o,
  input  logic              ls_data_ready_i,
  output logic [DATA_W-1:0] s_data_read_o,
  output logic              m_r_valid_o,
  input  logic              m_r_ready_i,
  output logic [ADDR_W-1:0] m_r_addr_o,
  output logic [7:0]        m_r_size_o,
  input  logic              m_data_valid_i,
  output logic              m_data_ready_o,
  input  logic [DATA_W-1:0] m_data_read_i
);

  localparam int STREAK_W = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  rd_state_e           state_r;
  rd_state_e           state_s;
  logic                owner_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [7:0]          size_r;
  logic [STREAK_W-1:0] streak_r;
  logic                grant_s;
  logic                win_ls_s;
  logic                owner_rdy_s;
  logic                data_done_s;

  // LS wins unless IF is waiting and LS has already used its full streak.
  function automatic logic pick_ls(input logic if_v, input logic ls_v,
                                   input logic streak_full);
    return ls_v && !(if_v && streak_full);
  endfunction

  // Winner selection and data-phase handshake terms.
  always_comb begin
    win_ls_s    = pick_ls(if_r_valid_i, ls_r_valid_i, streak_r == STREAK_MAX);
    owner_rdy_s = (owner_r == OWN_LS) ? ls_data_ready_i : if_data_ready_i;
    data_done_s = (state_r == RD_DATA) && m_data_valid_i && owner_rdy_s;
  end

  // Next-state logic; a grant only ever happens from IDLE.
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    case (state_r)
      RD_IDLE: begin
        if (if_r_valid_i || ls_r_valid_i) begin
          grant_s = 1'b1;
          state_s = RD_ADDR;
        end else begin
          state_s = RD_IDLE;
        end
      end
      RD_ADDR: begin
        if (m_r_ready_i) begin
          state_s = RD_DATA;
        end else begin
          state_s = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (data_done_s) begin
          state_s = RD_IDLE;
        end else begin
          state_s = RD_DATA;
        end
      end
      default: state_s = RD_IDLE;
    endcase
  end

  // State, captured request and fairness streak; reset drops any transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= RD_IDLE;
      owner_r  <= OWN_IF;
      addr_r   <= '0;
      size_r   <= 8'h00;
      streak_r <= '0;
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        owner_r <= win_ls_s ? OWN_LS : OWN_IF;
        addr_r  <= win_ls_s ? ls_r_addr_i : if_r_addr_i;
        size_r  <= win_ls_s ? ls_r_size_i : if_r_size_i;
        if (!win_ls_s) begin
          streak_r <= '0;
        end else if (if_r_valid_i && (streak_r != STREAK_MAX)) begin
          streak_r <= streak_r + STREAK_ONE;
        end else begin
          streak_r <= streak_r;
        end
      end
    end
  end

  assign if_r_ready_o    = grant_s && !win_ls_s;
  assign ls_r_ready_o    = grant_s && win_ls_s;
  assign m_r_valid_o     = (state_r == RD_ADDR);
  assign m_r_addr_o      = addr_r;
  assign m_r_size_o      = size_r;
  assign m_data_ready_o  = (state_r == RD_DATA) && owner_rdy_s;
  assign if_data_valid_o = (state_r == RD_DATA) && (owner_r == OWN_IF) && m_data_valid_i;
  assign ls_data_valid_o = (state_r == RD_DATA) && (owner_r == OWN_LS) && m_data_valid_i;
  assign s_data_read_o   = m_data_read_i;

endmodule

// File: doc/ysyx_22041207_rd_arbiter.md
YSYX_22041207_RD_ARBITER -- requirements
Module: ysyx_22041207_rd_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 64: request address width.
REQ-002 The block SHALL take parameter DATA_W, default 64: read data width.
REQ-003 The block SHALL take parameter MAX_LS_STREAK, default 4: consecutive LS grants allowed while IF waits.
REQ-004 The block SHALL have one clock; reset SHALL be synchronous and active-low, with ports clk and rst_n.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
if_r_valid_i  in  1  IF read request valid
if_r_ready_o  out  1  IF request accepted
if_r_addr_i  in  ADDR_W  IF request address
if_r_size_i  in  8  IF byte-strobe size
if_data_valid_o  out  1  IF read data valid
if_data_ready_i  in  1  IF ready for data
ls_r_valid_i  in  1  load/store read request valid
ls_r_ready_o  out  1  LS request accepted
ls_r_addr_i  in  ADDR_W  LS request address
ls_r_size_i  in  8  LS byte-strobe size
ls_data_valid_o  out  1  LS read data valid
ls_data_ready_i  in  1  LS ready for data
s_data_read_o  out  DATA_W  read data broadcast to both requesters
m_r_valid_o  out  1  downstream address valid
m_r_ready_i  in  1  downstream address accepted
m_r_addr_o  out  ADDR_W  downstream address (registered)
m_r_size_o  out  8  downstream size (registered)
m_data_valid_i  in  1  downstream data valid
m_data_ready_o  out  1  downstream data ready
m_data_read_i  in  DATA_W  downstream read data

Function
REQ-006 The FSM SHALL have the states IDLE, ADDR and DATA, and SHALL hold exactly one outstanding transaction.
REQ-007 IDLE: when any valid is high, the arbiter SHALL pick the winner, pulse its r_ready_o for one cycle, latch its addr, size and owner id, and enter ADDR.
REQ-008 Priority SHALL go to LS over IF, unless IF is valid and streak==MAX_LS_STREAK, in which case IF wins.
REQ-009 streak SHALL increment (saturating) on an LS grant while IF is valid, SHALL clear on an IF grant, and SHALL otherwise hold.
REQ-010 ADDR: m_r_valid_o SHALL be 1, with addr and size stable, until m_r_valid_o&&m_r_ready_i, then the FSM SHALL enter DATA; latency is grant cycle N, m_r_valid_o=1 from N+1.
REQ-011 DATA: the owner's data_valid_o SHALL equal m_data_valid_i, m_data_ready_o SHALL equal the owner's data_ready_i (combinational), and the non-owner's data_valid_o SHALL be 0.
REQ-012 DATA SHALL return to IDLE on m_data_valid_i&&m_data_ready_o; the next grant comes no earlier than the following cycle.
REQ-013 s_data_read_o SHALL be m_data_read_i unconditionally; consumers SHALL qualify it with data_valid_o.
REQ-014 Outside IDLE, both r_ready_o SHALL be 0; a requester dropping valid after acceptance SHALL have no effect.
REQ-015 m_data_valid_i in IDLE or ADDR SHALL be ignored, with m_data_ready_o=0 there.
REQ-016 A request arriving in the same cycle DATA completes SHALL be granted in IDLE on the next cycle.

Reset
REQ-017 When rst_n=0 at a clk edge, the block SHALL enter IDLE and clear streak, owner, m_r_addr_o and m_r_size_o; all valid/ready outputs SHALL be 0 after reset.
REQ-018 Reset mid-transaction SHALL drop it silently; the downstream slave SHALL be reset together with the block.

Structure
REQ-019 The FSM state enum and owner-id constants (OWN_IF=0, OWN_LS=1) SHALL live in the shared ysyx_22041207 package.
REQ-020 The design SHALL be single-module: the priority/streak pick SHALL be an internal function, with no sub-module.

Verification
REQ-021 IF only, addr 0x80000000, slave ready immediately -> if_r_ready_o pulses at cycle N, m_r_valid_o at N+1 with m_r_addr_o=0x80000000, data delivered to IF only.
REQ-022 IF and LS valid together from reset, MAX_LS_STREAK=4, LS held valid -> grants go LS,LS,LS,LS,IF,LS,...
REQ-023 m_r_ready_i held low 10 cycles -> m_r_valid_o stays 1, address stable, and no new grant occurs.
REQ-024 Data phase with ls_data_ready_i=0 for 3 cycles while m_data_valid_i=1 -> m_data_ready_o=0, FSM stays in DATA, and IF sees no data_valid.
REQ-025 rst_n pulled low during ADDR -> the next cycle is IDLE with m_r_valid_o=0 and streak=0, and a fresh request grants normally.
